// File: rtl/line_buffer_window.sv
// Circular line buffer presenting TAPS adjacent samples per read position, with
// occupancy tracking, flush and sticky overflow/underflow flags.
module line_buffer_window #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int TAPS   = 3,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_data_valid,
    output logic                     o_ready,
    input  logic                     i_rd_data,
    output logic [TAPS*DATA_W-1:0]   o_data,
    output logic                     o_data_valid,
    output logic [ADDR_W:0]          o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_ovf,
    output logic                     o_udf
);

    localparam logic [ADDR_W:0]   DepthC   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   TapsC    = (ADDR_W+1)'(TAPS);
    localparam logic [ADDR_W:0]   CntOneC  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PtrOneC  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LastC    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DepthLoC = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              rd_en, wr_en;

    assign o_full       = (count_q == DepthC);
    assign o_empty      = (count_q == '0);
    assign o_data_valid = (count_q >= TapsC);
    assign o_count      = count_q;
    assign o_ovf        = ovf_q;
    assign o_udf        = udf_q;

    assign rd_en   = i_rd_data & o_data_valid;
    assign o_ready = ~o_full | rd_en;
    // Flush wins over a simultaneous write, so the storage write is gated too.
    assign wr_en   = i_data_valid & o_ready & ~i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = (wr_ptr_q == LastC) ? '0 : wr_ptr_q + PtrOneC;
            end
            if (rd_en) begin
                rd_ptr_d = (rd_ptr_q == LastC) ? '0 : rd_ptr_q + PtrOneC;
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CntOneC;
                2'b01:   count_d = count_q - CntOneC;
                default: count_d = count_q;
            endcase
            if (i_data_valid && !o_ready) begin
                ovf_d = 1'b1;
            end
            if (i_rd_data && !o_data_valid) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    // Tap k sits at rd_ptr+k; when that passes the end, subtract DEPTH (modular in ADDR_W bits
    // is exact because the true index is always below DEPTH).
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        localparam logic [ADDR_W:0]   WrapAtC = (ADDR_W+1)'(DEPTH - k);
        localparam logic [ADDR_W-1:0] KC      = ADDR_W'(k);
        logic [ADDR_W-1:0] idx;
        assign idx = ({1'b0, rd_ptr_q} >= WrapAtC) ? rd_ptr_q + KC - DepthLoC
                                                   : rd_ptr_q + KC;
        assign o_data[k*DATA_W +: DATA_W] = mem[idx];
    end

endmodule

// File: tb/tb_line_buffer_window.sv
// Bench for line_buffer_window: a small DEPTH=6 instance driven from a vector table plus
// hand sequences, and a wide 32-bit/512-deep instance checked against a queue model.
module tb_line_buffer_window;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        s_flush, s_valid, s_rd, s_ready, s_dv, s_full, s_empty, s_ovf, s_udf;
    logic [7:0]  s_din;
    logic [23:0] s_dout;
    logic [3:0]  s_count;

    logic        w_flush, w_valid, w_rd, w_ready, w_dv, w_full, w_empty, w_ovf, w_udf;
    logic [31:0] w_din;
    logic [95:0] w_dout;
    logic [9:0]  w_count;

    line_buffer_window #(.DATA_W(8), .DEPTH(6), .TAPS(3)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(s_flush), .i_data(s_din),
        .i_data_valid(s_valid), .o_ready(s_ready), .i_rd_data(s_rd), .o_data(s_dout),
        .o_data_valid(s_dv), .o_count(s_count), .o_full(s_full), .o_empty(s_empty),
        .o_ovf(s_ovf), .o_udf(s_udf)
    );

    line_buffer_window #(.DATA_W(32), .DEPTH(512), .TAPS(3)) u_wide (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(w_flush), .i_data(w_din),
        .i_data_valid(w_valid), .o_ready(w_ready), .i_rd_data(w_rd), .o_data(w_dout),
        .o_data_valid(w_dv), .o_count(w_count), .o_full(w_full), .o_empty(w_empty),
        .o_ovf(w_ovf), .o_udf(w_udf)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // fl = {data_valid, full, empty, ovf, udf} after the edge; rdy is sampled before it.
    typedef struct {
        logic       flush;
        logic       wv;
        logic       rd;
        logic [7:0] d;
        logic       rdy;
        logic [3:0] cnt;
        logic [4:0] fl;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [7:0] t2;
    } vec_t;

    typedef struct {
        logic [9:0]  cnt;
        logic        dv;
        logic [95:0] taps;
    } exp_t;

    vec_t        vecs[22];
    exp_t        sb[$];
    logic [31:0] model[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   written;
        int   cyc;
        logic do_rd, do_wr;
        logic [31:0] d;
        exp_t e, g;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 4'd1, 5'b00000, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 4'd2, 5'b00000, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 4'd3, 5'b10000, 8'h01, 8'h02, 8'h03};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 4'd4, 5'b10000, 8'h01, 8'h02, 8'h03};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 4'd5, 5'b10000, 8'h01, 8'h02, 8'h03};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd4, 5'b10000, 8'h02, 8'h03, 8'h04};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd3, 5'b10000, 8'h03, 8'h04, 8'h05};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h06, 1'b1, 4'd4, 5'b10000, 8'h03, 8'h04, 8'h05};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h07, 1'b1, 4'd5, 5'b10000, 8'h03, 8'h04, 8'h05};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 4'd6, 5'b11000, 8'h03, 8'h04, 8'h05};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 4'd6, 5'b11000, 8'h04, 8'h05, 8'h06};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 4'd6, 5'b11010, 8'h04, 8'h05, 8'h06};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd5, 5'b10010, 8'h05, 8'h06, 8'h07};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd4, 5'b10010, 8'h06, 8'h07, 8'h08};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd3, 5'b10010, 8'h07, 8'h08, 8'hAA};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd2, 5'b00010, 8'h00, 8'h00, 8'h00};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 4'd2, 5'b00011, 8'h00, 8'h00, 8'h00};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h09, 1'b1, 4'd3, 5'b10011, 8'h08, 8'hAA, 8'h09};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 4'd0, 5'b00100, 8'h00, 8'h00, 8'h00};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 4'd1, 5'b00000, 8'h00, 8'h00, 8'h00};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 4'd2, 5'b00000, 8'h00, 8'h00, 8'h00};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 4'd3, 5'b10000, 8'h11, 8'h22, 8'h44};

        rst_n   = 1'b0;
        s_flush = 1'b0; s_valid = 1'b0; s_rd = 1'b0; s_din = '0;
        w_flush = 1'b0; w_valid = 1'b0; w_rd = 1'b0; w_din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 128'(s_count), 128'(0));
        chk("reset flags", 128'({s_ready, s_dv, s_full, s_empty, s_ovf, s_udf}),
            128'(6'b100100));
        chk("reset wide count", 128'(w_count), 128'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            s_flush = vecs[i].flush;
            s_valid = vecs[i].wv;
            s_rd    = vecs[i].rd;
            s_din   = vecs[i].d;
            #1;
            chk($sformatf("v%0d ready", i), 128'(s_ready), 128'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i), 128'(s_count), 128'(vecs[i].cnt));
            chk($sformatf("v%0d flags", i), 128'({s_dv, s_full, s_empty, s_ovf, s_udf}),
                128'(vecs[i].fl));
            if (vecs[i].fl[4]) begin
                chk($sformatf("v%0d taps", i), 128'(s_dout),
                    128'({vecs[i].t2, vecs[i].t1, vecs[i].t0}));
            end
        end
        s_flush = 1'b0; s_valid = 1'b0; s_rd = 1'b0;

        // Wide instance: random interleave of writes and slides against a queue model.
        written = 0;
        cyc     = 0;
        while ((written < 600 || model.size() >= 3) && cyc < 5000) begin
            d     = $urandom;
            do_wr = (written < 600);
            do_rd = (written >= 600) || ($urandom_range(0, 3) == 0);
            if (model.size() < 3) do_rd = 1'b0;
            if (model.size() == 512 && !do_rd) do_wr = 1'b0;
            w_valid = do_wr;
            w_rd    = do_rd;
            w_din   = d;
            if (do_rd) void'(model.pop_front());
            if (do_wr) begin
                model.push_back(d);
                written++;
            end
            e.cnt  = 10'(model.size());
            e.dv   = (model.size() >= 3);
            e.taps = e.dv ? {model[2], model[1], model[0]} : '0;
            sb.push_back(e);
            @(posedge clk);
            #1;
            g = sb.pop_front();
            chk($sformatf("wide c%0d count", cyc), 128'(w_count), 128'(g.cnt));
            if (g.dv) begin
                chk($sformatf("wide c%0d taps", cyc), 128'(w_dout), 128'(g.taps));
            end
            cyc++;
        end
        w_valid = 1'b0;
        w_rd    = 1'b0;
        chk("wide budget", 128'(cyc < 5000), 128'(1));
        chk("wide errors", 128'({w_ovf, w_udf}), 128'(2'b00));

        // Asynchronous reset in the middle of a clock-high phase, then refill 1,2,3.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst count", 128'(s_count), 128'(0));
        chk("async rst flags", 128'({s_ready, s_dv, s_full, s_empty}), 128'(4'b1001));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            s_valid = 1'b1;
            s_din   = 8'(k);
            @(posedge clk);
            #1;
            chk($sformatf("refill %0d valid", k), 128'(s_dv), 128'(k == 3));
        end
        s_valid = 1'b0;
        chk("refill count", 128'(s_count), 128'(3));
        chk("refill taps", 128'(s_dout), 128'(24'h030201));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_buffer_window.md
Name: line_buffer_window

Overview:
- Parametrised successor to the fixed 8-bit/512-entry line buffer.
- Circular pixel store with configurable data width, depth and window tap count.
- Adds occupancy tracking, full/empty/ready flags, a window-valid qualifier, synchronous flush and sticky overflow/underflow error flags.
- Sits between pixel source and the convolution/gradient stages of the Harris pipeline; one instance per image row of the window.

Parameters:
DATA_W, 8, pixel/intermediate sample width in bits (32 for gradient-product rows).
DEPTH, 512, number of storage entries; any integer >= TAPS, not required to be a power of 2.
TAPS, 3, number of horizontally adjacent samples presented per read position (1..8).
ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
i_clk  in  1  sole clock, rising edge.
i_rst_n  in  1  reset, asynchronous assert, active-low.
i_flush  in  1  synchronous clear of pointers, count and error flags.
i_data  in  DATA_W  write sample.
i_data_valid  in  1  write request.
o_ready  out  1  high when a write is accepted this cycle.
i_rd_data  in  1  advance read position by one sample (window slide).
o_data  out  TAPS*DATA_W  window taps; tap k at bits [k*DATA_W +: DATA_W], tap 0 = oldest.
o_data_valid  out  1  count >= TAPS; taps are meaningful.
o_count  out  ADDR_W+1  number of stored samples, 0..DEPTH.
o_full  out  1  count == DEPTH.
o_empty  out  1  count == 0.
o_ovf  out  1  sticky: write attempted while not ready.
o_udf  out  1  sticky: read attempted while o_data_valid low.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (i_rst_n=0): wr_ptr=0, rd_ptr=0, count=0, o_ovf=0, o_udf=0. Outputs are then o_ready=1, o_empty=1, o_full=0, o_data_valid=0, o_count=0. Memory contents are not reset.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Release is synchronised externally.
- i_flush: same effect as reset on the next rising edge. It has priority over any simultaneous read or write; that cycle's write is dropped.
- Write acceptance: wr_en = i_data_valid & o_ready.
  - o_ready = !o_full | rd_en, so a simultaneous slide frees one slot.
  - On wr_en: mem[wr_ptr] <= i_data; wr_ptr increments and wraps DEPTH-1 -> 0.
- Read acceptance: rd_en = i_rd_data & o_data_valid. On rd_en, rd_ptr increments with the same wrap.
- Count update:
  - +1 on wr_en only.
  - -1 on rd_en only.
  - Unchanged when both or neither occur.
- Taps: combinational from storage. Tap k = mem[(rd_ptr+k) mod DEPTH].
  - Wrap is computed explicitly (subtract DEPTH when the sum >= DEPTH), not by bit truncation.
  - Zero added latency: a write at edge N is visible on taps after edge N.
- Read/write latency: a sample written at edge N contributes to o_data_valid and o_count from edge N onward (flags registered from count).
- Full + write without read: write is dropped, o_ovf set; storage and pointers are unchanged.
- Read with count < TAPS: rd_ptr is unchanged, o_udf set.
- o_ovf and o_udf clear only on reset or flush.
- Flags o_full, o_empty and o_data_valid are derived from the registered count, with no combinational path from inputs.
- Exception: o_ready depends combinationally on i_rd_data.
- No internal state machine beyond the pointer/count registers. Implementation uses an inferred memory plus a TAPS-way read mux generated by loop.

Test Plan:
- Reset and fill: DATA_W=8, DEPTH=8, TAPS=3. Assert i_rst_n=0 mid-stream, then release and write 1,2,3. Required: o_count=3, o_data_valid rises after the 3rd edge, taps = {3,2,1} (tap0=1).
- Slide: after 5 writes (1..5), pulse i_rd_data twice. Required: taps go {4,3,2} then {5,4,3}, o_count=3, o_udf=0.
- Wrap: DEPTH=6 (non-power-of-2). Write 1..6, read 4, write 7..9. Required: o_full=1 at count 6; final taps = {7,6,5}, i.e. mem indices 4,5,0 are read across the wrap.
- Full with simultaneous read/write: at count=DEPTH, drive i_data_valid=1 and i_rd_data=1 with value 0xAA. Required: o_ready=1, count stays DEPTH, no o_ovf. Write alone at full: o_ready=0, o_ovf=1, data unchanged.
- Underflow and flush: with count=2, pulse i_rd_data. Required: o_udf=1, rd_ptr unchanged. Then i_flush with i_data_valid=1. Required: count=0, o_empty=1, o_udf=0, write dropped.
- Wide config: DATA_W=32, TAPS=3, DEPTH=512. Stream 600 writes interleaved with reads. Required: taps match a reference queue model every cycle, no o_ovf/o_udf.
